// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, FSM states,
// shift-amount width and a small classification helper. The ALU control
// decoder imports the same package so the codes have one source of truth.
package alu_exec_unit_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned SHAMT_W    = 5;

    // ALU control codes produced by the ALU control decoder
    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SRA = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_XOR = 4'b1010,
        ALU_NOR = 4'b1011
    } alu_ctrl_e;

    // Execute FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // True for the three codes handled by the iterative shifter
    function automatic logic is_shift(input logic [ALU_CTRL_W-1:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the multi-cycle shifter (combinational).
// Ports: work (word being shifted), dir (0=left, 1=right), arith (replicate
// the sign bit on right shifts), step (positions to shift this cycle),
// shifted (result word).
module alu_shift_step #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STEP_W = 1
) (
    input  logic [WIDTH-1:0]  work,
    input  logic              dir,
    input  logic              arith,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  shifted
);

    always_comb begin
        shifted = work;
        if (!dir) begin
            shifted = work << step;
        end else if (arith) begin
            shifted = WIDTH'($signed(work) >>> step);
        end else begin
            shifted = work >> step;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Logic ops, add, sub and slt finish in one cycle; sll/srl/sra iterate over
// the shifter, SHIFT_STEP positions per cycle.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, alu_ctrl, op_a,
// op_b, shamt (issue side); out_valid/out_ready, result, zero, overflow
// (MEM side). in_ready is combinational.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic [SHAMT_W-1:0]    shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
    output logic                  overflow
);

    localparam int unsigned STEP_W = $clog2(SHIFT_STEP + 1);

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 overflow_q, overflow_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   rem_q, rem_d;
    logic                 dir_q, dir_d;
    logic                 arith_q, arith_d;

    logic [WIDTH-1:0]     sum_c, diff_c, alu_res_c, shifted_c;
    logic                 alu_ovf_c, accept_c;
    logic [STEP_W-1:0]    step_c;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept_c  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

    assign sum_c  = op_a + op_b;
    assign diff_c = op_a - op_b;

    // Single-cycle ALU; undefined codes fall through to add
    always_comb begin
        alu_res_c = sum_c;
        alu_ovf_c = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_c[WIDTH-1] != op_a[WIDTH-1]);
        case (alu_ctrl)
            ALU_AND: begin alu_res_c = op_a & op_b;    alu_ovf_c = 1'b0; end
            ALU_OR:  begin alu_res_c = op_a | op_b;    alu_ovf_c = 1'b0; end
            ALU_XOR: begin alu_res_c = op_a ^ op_b;    alu_ovf_c = 1'b0; end
            ALU_NOR: begin alu_res_c = ~(op_a | op_b); alu_ovf_c = 1'b0; end
            ALU_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_c[WIDTH-1] != op_a[WIDTH-1]);
            end
            // Real signed compare, immune to subtraction overflow
            ALU_SLT: begin
                alu_res_c = WIDTH'(($signed(op_a) < $signed(op_b)) ? 1 : 0);
                alu_ovf_c = 1'b0;
            end
            // Only reached with shamt==0: the operand passes through
            ALU_SLL, ALU_SRL, ALU_SRA: begin alu_res_c = op_b; alu_ovf_c = 1'b0; end
            default: ;
        endcase
    end

    // Last iteration may be shorter than SHIFT_STEP
    always_comb begin
        if (rem_q < SHAMT_W'(SHIFT_STEP)) begin
            step_c = STEP_W'(rem_q);
        end else begin
            step_c = STEP_W'(SHIFT_STEP);
        end
    end

    alu_shift_step #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_shift_step (
        .work    (work_q),
        .dir     (dir_q),
        .arith   (arith_q),
        .step    (step_c),
        .shifted (shifted_c)
    );

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        work_d      = work_q;
        rem_d       = rem_q;
        dir_d       = dir_q;
        arith_d     = arith_q;

        case (state_q)
            ST_IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept_c) begin
                    if (is_shift(alu_ctrl) && (shamt != '0)) begin
                        work_d  = op_b;
                        rem_d   = shamt;
                        dir_d   = (alu_ctrl != ALU_SLL);
                        arith_d = (alu_ctrl == ALU_SRA);
                        state_d = ST_SHIFT;
                    end else begin
                        result_d    = alu_res_c;
                        zero_d      = (alu_res_c == '0);
                        overflow_d  = alu_ovf_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted_c;
                rem_d  = rem_q - SHAMT_W'(step_c);
                // Output register is known empty here, so load directly
                if (rem_q == SHAMT_W'(step_c)) begin
                    result_d    = shifted_c;
                    zero_d      = (shifted_c == '0);
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            work_q      <= '0;
            rem_q       <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            dir_q       <= dir_d;
            arith_q     <= arith_d;
        end
    end

endmodule
